// File: rtl/servo_bank.sv
// servo_bank: multi-channel RC servo pulse generator.
// One registered PWM pulse per channel per frame. The pulse width is
// MIN_CLKS + cur*STEP_CLKS. Written targets reach `cur` only at a frame
// boundary, so a pulse is never cut short or stretched.
// Optional macro SERVO_SLEW_EN: each boundary moves `cur` at most SLEW_STEP
// toward `target`. When the macro is undefined, `cur` copies `target`.
module servo_bank #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned VAL_BITS   = 8,
  parameter int unsigned FRAME_CLKS = 1_000_000,
  parameter int unsigned MIN_CLKS   = 50_000,
  parameter int unsigned STEP_CLKS  = 196,
  parameter int unsigned SLEW_STEP  = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           wr_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
  input  logic [VAL_BITS-1:0]                            wr_val,
  output logic                                           wr_ack,
  output logic                                           wr_err,
  output logic                                           frame_start,
  output logic [NUM_CH-1:0]                              servo
);

  localparam int unsigned CH_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_BITS = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam logic [VAL_BITS-1:0] CENTRE = VAL_BITS'(1) << (VAL_BITS - 1);
  localparam logic [63:0] MAX_W =
    64'(MIN_CLKS) + ((64'd1 << VAL_BITS) - 64'd1) * 64'(STEP_CLKS);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("servo_bank: NUM_CH must be in 1..16");
  end
  if (MAX_W >= 64'(FRAME_CLKS)) begin : g_bad_timing
    $error("servo_bank: MIN_CLKS + (2^VAL_BITS-1)*STEP_CLKS must be below FRAME_CLKS");
  end
  if (SLEW_STEP < 1) begin : g_bad_slew
    $error("servo_bank: SLEW_STEP must be at least 1");
  end

  logic [CNT_BITS-1:0] cnt;
  logic                boundary;
  logic                wr_ok;
  logic [VAL_BITS-1:0] target   [NUM_CH];
  logic [VAL_BITS-1:0] cur      [NUM_CH];
  logic [VAL_BITS-1:0] cur_next [NUM_CH];
  logic [CNT_BITS-1:0] width    [NUM_CH];

  assign boundary = (cnt == CNT_BITS'(FRAME_CLKS - 1));
  assign wr_ok    = (32'(wr_ch) < NUM_CH);

  // Frame counter: 0..FRAME_CLKS-1, then wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (boundary) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_BITS'(1);
    end
  end

  // Target capture on write. Cur is loaded only at the frame boundary. The
  // boundary sees the pre-write target because both updates are non-blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        target[i] <= CENTRE;
        cur[i]    <= CENTRE;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr_en && wr_ok && (wr_ch == CH_BITS'(i))) begin
          target[i] <= wr_val;
        end
        if (boundary) begin
          cur[i] <= cur_next[i];
        end
      end
    end
  end

`ifdef SERVO_SLEW_EN
  // Slew-limited step toward target. The compare is done in int so that the
  // step cannot wrap past either end of the position range.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cur_next[i] = target[i];
      if (int'(target[i]) > int'(cur[i]) + int'(SLEW_STEP)) begin
        cur_next[i] = cur[i] + VAL_BITS'(SLEW_STEP);
      end else if (int'(target[i]) + int'(SLEW_STEP) < int'(cur[i])) begin
        cur_next[i] = cur[i] - VAL_BITS'(SLEW_STEP);
      end
    end
  end
`else
  // Without slew the boundary copies target straight into cur.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cur_next[i] = target[i];
    end
  end
`endif

  // Pulse width per channel. The parameter rule keeps it below FRAME_CLKS.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      width[i] = CNT_BITS'(MIN_CLKS) + CNT_BITS'(cur[i]) * CNT_BITS'(STEP_CLKS);
    end
  end

  // Write handshake pulses, one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= wr_en && wr_ok;
      wr_err <= wr_en && !wr_ok;
    end
  end

  // Registered outputs: frame_start and each servo rise together after cnt==0.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
      servo       <= '0;
    end else begin
      frame_start <= (cnt == '0);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        servo[i] <= (cnt < width[i]);
      end
    end
  end

endmodule
